// File: rtl/regfile_arbiter.sv
// Two-master access arbiter and sequencer for the 16-bit register file's rd/rs ports.
// Define REGFILE_ARB_RR_EN for round-robin on contention; otherwise M0 has fixed priority.
module regfile_arbiter #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [15:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [15:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [15:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [15:0]       m1_rdata,
  input  logic              clr_req,
  output logic              clr_done,
  output logic [AWIDTH-1:0] rf_addr_rs,
  output logic              rf_req_rs,
  output logic [AWIDTH-1:0] rf_addr_rd,
  output logic              rf_req_rd,
  output logic [15:0]       rf_wdata,
  output logic              rf_clear,
  input  logic [15:0]       rf_rs,
  output logic              busy
);
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {IDLE, WR, RD, RSP, CLR} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
`ifdef REGFILE_ARB_RR_EN
  logic                last_q, last_d;
`endif
  logic                m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic                rf_req_rs_q, rf_req_rs_d, rf_req_rd_q, rf_req_rd_d;
  logic                rf_clear_q, rf_clear_d;
  logic [AWIDTH-1:0]   rf_addr_rs_q, rf_addr_rs_d, rf_addr_rd_q, rf_addr_rd_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

  logic                win;
  logic                win_we;
  logic [AWIDTH-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // win is only meaningful when at least one master is requesting
  always_comb begin
`ifdef REGFILE_ARB_RR_EN
    win = (m0_req && m1_req) ? ~last_q : m1_req;
`else
    win = ~m0_req;
`endif
    win_we    = win ? m1_we    : m0_we;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
`ifdef REGFILE_ARB_RR_EN
    last_d       = last_q;
`endif
    m0_gnt_d     = 1'b0;
    m1_gnt_d     = 1'b0;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    rf_req_rs_d  = 1'b0;
    rf_req_rd_d  = 1'b0;
    rf_clear_d   = 1'b0;
    rf_addr_rs_d = rf_addr_rs_q;
    rf_addr_rd_d = rf_addr_rd_q;
    rf_wdata_d   = rf_wdata_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLR;
          rf_clear_d = 1'b1;
        end else if (m0_req || m1_req) begin
          owner_d  = win;
`ifdef REGFILE_ARB_RR_EN
          last_d   = win;
`endif
          m0_gnt_d = ~win;
          m1_gnt_d = win;
          if (win_we) begin
            state_d      = WR;
            rf_req_rd_d  = 1'b1;
            rf_addr_rd_d = win_addr;
            rf_wdata_d   = win_wdata;
          end else begin
            state_d      = RD;
            rf_req_rs_d  = 1'b1;
            rf_addr_rs_d = win_addr;
          end
        end
      end
      // regfile captures the read at the end of RD; data is on rf_rs during RSP
      RD: begin
        state_d     = RSP;
        m0_rvalid_d = ~owner_q;
        m1_rvalid_d = owner_q;
      end
      WR, RSP, CLR: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
`ifdef REGFILE_ARB_RR_EN
      last_q       <= 1'b1;
`endif
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_rvalid_q  <= 1'b0;
      m1_rvalid_q  <= 1'b0;
      rf_req_rs_q  <= 1'b0;
      rf_req_rd_q  <= 1'b0;
      rf_clear_q   <= 1'b0;
      rf_addr_rs_q <= '0;
      rf_addr_rd_q <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
`ifdef REGFILE_ARB_RR_EN
      last_q       <= last_d;
`endif
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      m0_rvalid_q  <= m0_rvalid_d;
      m1_rvalid_q  <= m1_rvalid_d;
      rf_req_rs_q  <= rf_req_rs_d;
      rf_req_rd_q  <= rf_req_rd_d;
      rf_clear_q   <= rf_clear_d;
      rf_addr_rs_q <= rf_addr_rs_d;
      rf_addr_rd_q <= rf_addr_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign m0_gnt     = m0_gnt_q;
  assign m1_gnt     = m1_gnt_q;
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign m0_rdata   = rf_rs;
  assign m1_rdata   = rf_rs;
  assign rf_req_rs  = rf_req_rs_q;
  assign rf_req_rd  = rf_req_rd_q;
  assign rf_addr_rs = rf_addr_rs_q;
  assign rf_addr_rd = rf_addr_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign rf_clear   = rf_clear_q;
  assign clr_done   = rf_clear_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: transaction-scheduling reference model plus a simple regfile.
module tb_regfile_arbiter;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req, we;
  logic [AW-1:0] addr [2];
  logic [15:0]   wdata [2];
  logic          clr;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, clr_done;
  logic          rf_req_rs, rf_req_rd, rf_clear, busy;
  logic [15:0]   m0_rdata, m1_rdata, rf_wdata, rf_rs;
  logic [AW-1:0] rf_addr_rs, rf_addr_rd;

  regfile_arbiter #(.AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .clr_req(clr), .clr_done(clr_done),
    .rf_addr_rs(rf_addr_rs), .rf_req_rs(rf_req_rs),
    .rf_addr_rd(rf_addr_rd), .rf_req_rd(rf_req_rd), .rf_wdata(rf_wdata),
    .rf_clear(rf_clear), .rf_rs(rf_rs), .busy(busy)
  );

  // Regfile stand-in: synchronous write/clear, registered rs read
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n || rf_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (rf_req_rd) begin
      mem[rf_addr_rd] <= rf_wdata;
    end
    if (rf_req_rs) rf_rs <= mem[rf_addr_rs];
  end

  int checks = 0, failures = 0;
  int cyc = 0, free_at = 0, mode = 0;
`ifdef REGFILE_ARB_RR_EN
  int last_m = 1;
`endif
  logic [15:0]   m_mem [256];
  logic [AW-1:0] h_addr_rd, h_addr_rs;
  logic [15:0]   h_wdata;
  logic [1:0]    e_gnt [4];
  logic [1:0]    e_rv [4];
  logic          e_rd [4], e_rs [4], e_clr [4];
  logic [15:0]   e_rdata [4];
  logic [1:0]    cur_gnt;
  logic          cur_clr;
  bit            nxt_v [2], nxt_we [2], nxt_clr;
  logic [AW-1:0] nxt_addr [2];
  logic [15:0]   nxt_data [2];
  int            gq [$];
  int            gnt_cyc [2], rv_cyc [2], rv_cnt [2], clr_cyc;
  logic [15:0]   rv_data [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rf_req_rd, rf_req_rs, rf_clear,
               clr_done, busy, rf_addr_rd, rf_addr_rs, rf_wdata}, 64'd0);
  endtask

  task automatic post(input int m, input bit w, input logic [AW-1:0] a, input logic [15:0] d);
    nxt_v[m] = 1'b1; nxt_we[m] = w; nxt_addr[m] = a; nxt_data[m] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      e_gnt[i] = '0; e_rv[i] = '0; e_rd[i] = 1'b0; e_rs[i] = 1'b0; e_clr[i] = 1'b0; e_rdata[i] = '0;
    end
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    free_at = cyc;
`ifdef REGFILE_ARB_RR_EN
    last_m = 1;
`endif
    h_addr_rd = '0; h_addr_rs = '0; h_wdata = '0;
  endtask

  task automatic gen();
    case (mode)
      1: begin
        for (int m = 0; m < 2; m++)
          if (!req[m] && !nxt_v[m] && $urandom_range(1) == 1)
            post(m, 1'($urandom_range(1)), AW'($urandom_range(7)), 16'($urandom));
        if (!clr && !nxt_clr && $urandom_range(15) == 0) nxt_clr = 1'b1;
      end
      2: begin
        if (!req[0] && !nxt_v[0]) post(0, 1'b1, 8'h11, 16'h1111);
        if (!req[1] && !nxt_v[1]) post(1, 1'b1, 8'h22, 16'h2222);
      end
      3: if (!req[1] && !nxt_v[1]) post(1, 1'b0, 8'h22, 16'h0000);
      default: ;
    endcase
    for (int m = 0; m < 2; m++)
      if (!req[m] && nxt_v[m]) begin
        req[m] = 1'b1; we[m] = nxt_we[m]; addr[m] = nxt_addr[m]; wdata[m] = nxt_data[m];
        nxt_v[m] = 1'b0;
      end
    if (!clr && nxt_clr) begin clr = 1'b1; nxt_clr = 1'b0; end
  endtask

  // Advance one cycle, compare every DUT output with the model, then run the masters
  task automatic tick();
    int s;
    @(posedge clk); #1;
    cyc++;
    s = cyc % 4;
    chk("m0_gnt", m0_gnt, e_gnt[s][0]);
    chk("m1_gnt", m1_gnt, e_gnt[s][1]);
    chk("m0_rvalid", m0_rvalid, e_rv[s][0]);
    chk("m1_rvalid", m1_rvalid, e_rv[s][1]);
    chk("rf_req_rd", rf_req_rd, e_rd[s]);
    chk("rf_req_rs", rf_req_rs, e_rs[s]);
    chk("rf_clear", rf_clear, e_clr[s]);
    chk("clr_done", clr_done, e_clr[s]);
    chk("busy", busy, cyc < free_at);
    chk("rf_addr_rd", rf_addr_rd, h_addr_rd);
    chk("rf_wdata", rf_wdata, h_wdata);
    chk("rf_addr_rs", rf_addr_rs, h_addr_rs);
    if (e_rv[s][0]) chk("m0_rdata", m0_rdata, e_rdata[s]);
    if (e_rv[s][1]) chk("m1_rdata", m1_rdata, e_rdata[s]);
    if (m0_gnt) begin gq.push_back(0); gnt_cyc[0] = cyc; end
    if (m1_gnt) begin gq.push_back(1); gnt_cyc[1] = cyc; end
    if (m0_rvalid) begin rv_cyc[0] = cyc; rv_data[0] = m0_rdata; rv_cnt[0]++; end
    if (m1_rvalid) begin rv_cyc[1] = cyc; rv_data[1] = m1_rdata; rv_cnt[1]++; end
    if (clr_done) clr_cyc = cyc;
    cur_gnt = e_gnt[s];
    cur_clr = e_clr[s];
    e_gnt[s] = '0; e_rv[s] = '0; e_rd[s] = 1'b0; e_rs[s] = 1'b0; e_clr[s] = 1'b0;
    for (int m = 0; m < 2; m++) if (cur_gnt[m]) req[m] = 1'b0;
    if (cur_clr) clr = 1'b0;
    gen();
  endtask

  // Transaction-level scheduling: a decision in an idle cycle fixes the next 1-2 cycles
  task automatic arb();
    int w, s1, s2;
    if (cyc >= free_at) begin
      s1 = (cyc + 1) % 4;
      s2 = (cyc + 2) % 4;
      if (clr) begin
        e_clr[s1] = 1'b1;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        free_at = cyc + 2;
      end else if (req != 2'b00) begin
`ifdef REGFILE_ARB_RR_EN
        if (req == 2'b11) w = 1 - last_m;
        else w = req[1] ? 1 : 0;
        last_m = w;
`else
        w = req[0] ? 0 : 1;
`endif
        e_gnt[s1][w] = 1'b1;
        if (we[w]) begin
          e_rd[s1] = 1'b1;
          h_addr_rd = addr[w];
          h_wdata = wdata[w];
          m_mem[addr[w]] = wdata[w];
          free_at = cyc + 2;
        end else begin
          e_rs[s1] = 1'b1;
          h_addr_rs = addr[w];
          e_rv[s2][w] = 1'b1;
          e_rdata[s2] = m_mem[addr[w]];
          free_at = cyc + 3;
        end
      end
    end
  endtask

  task automatic cycle();
    tick();
    arb();
  endtask

  task automatic run_quiet(input string name, input int budget);
    int n = 0;
    while (!(req == 2'b00 && !clr && !nxt_v[0] && !nxt_v[1] && !nxt_clr && cyc >= free_at)
           && n < budget) begin
      cycle();
      n++;
    end
    chk({name, "_done"}, n < budget, 1);
  endtask

  task automatic apply_reset(input bit check_async);
    rst_n = 1'b0;
    req = 2'b00; clr = 1'b0; nxt_v[0] = 0; nxt_v[1] = 0; nxt_clr = 0;
    model_reset();
    #1;
    if (check_async) chk_zero("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;
    arb();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, n_seen, prev, consec, ng;
    bit hit, pg, pr;
    req = 2'b00; we = 2'b00; clr = 1'b0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    rv_cnt[0] = 0; rv_cnt[1] = 0; clr_cyc = -1;
    apply_reset(1'b0);

    // Write then read back through M0, with latency pinned
    post(0, 1'b1, 8'h05, 16'hBEEF);
    run_quiet("t1w", 20);
    gnt_cyc[0] = -100; rv_cyc[0] = -100; rv_data[0] = 16'h0000;
    post(0, 1'b0, 8'h05, 16'h0000);
    p = cyc + 1;
    run_quiet("t1r", 20);
    chk("t1_gnt_lat", gnt_cyc[0] - p, 1);
    chk("t1_rv_lat", rv_cyc[0] - p, 2);
    chk("t1_rdata", rv_data[0], 16'hBEEF);

    // Both masters write continuously from reset
    apply_reset(1'b0);
    gq.delete();
    mode = 2;
    repeat (14) cycle();
    mode = 0;
    n_seen = gq.size();
    chk("t2_count", n_seen, 7);
    for (int i = 0; i < n_seen; i++) begin
`ifdef REGFILE_ARB_RR_EN
      chk("t2_order", gq[i], i % 2);
`else
      chk("t2_order", gq[i], 0);
`endif
    end
    run_quiet("t2", 40);

    // Same-cycle M0 write and M1 read of the same register
    apply_reset(1'b0);
    rv_data[1] = 16'h0000;
    post(0, 1'b1, 8'h22, 16'hAAAA);
    post(1, 1'b0, 8'h22, 16'h0000);
    run_quiet("t3", 20);
    chk("t3_rdata", rv_data[1], 16'hAAAA);
    chk("t3_order", gnt_cyc[0] < gnt_cyc[1], 1);

    // Clear wins over a same-cycle read
    post(0, 1'b1, 8'h10, 16'h1234);
    run_quiet("t4w", 20);
    rv_data[0] = 16'hFFFF;
    nxt_clr = 1'b1;
    post(0, 1'b0, 8'h10, 16'h0000);
    run_quiet("t4", 20);
    chk("t4_order", clr_cyc < gnt_cyc[0], 1);
    chk("t4_rdata", rv_data[0], 16'h0000);

    // Reset while a read is in flight
    post(0, 1'b0, 8'h33, 16'h0000);
    hit = 0;
    for (int n = 0; n < 8 && !hit; n++) begin
      tick();
      if (cur_gnt[0]) hit = 1;
      else arb();
    end
    chk("t5_reached_rd", hit, 1);
    rv_cnt[0] = 0;
    apply_reset(1'b1);
    repeat (4) cycle();
    chk("t5_no_rvalid", rv_cnt[0], 0);
    post(0, 1'b1, 8'h33, 16'h5A5A);
    run_quiet("t5w", 20);
    rv_data[0] = 16'h0000;
    post(0, 1'b0, 8'h33, 16'h0000);
    run_quiet("t5r", 20);
    chk("t5_rdata", rv_data[0], 16'h5A5A);

    // M1 holds a read request
    apply_reset(1'b0);
    mode = 3;
    prev = -1; consec = 0; ng = 0; pg = 0; pr = 0;
    repeat (13) begin
      cycle();
      if (m1_gnt) begin
        ng++;
        if (prev >= 0) chk("t6_spacing", cyc - prev, 3);
        prev = cyc;
      end
      if ((m1_gnt && pg) || (m1_rvalid && pr)) consec++;
      pg = m1_gnt;
      pr = m1_rvalid;
    end
    mode = 0;
    run_quiet("t6", 20);
    chk("t6_consec", consec, 0);
    chk("t6_ngnt", ng, 4);

    // Random traffic including clears
    apply_reset(1'b0);
    mode = 1;
    repeat (800) cycle();
    mode = 0;
    run_quiet("t7", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
